// File: rtl/m_tile_sched_if.sv
// Signal bundle between the tile scheduler and its command source, buffers and array.
// master = scheduler side, slave = controller/buffer/array side.
interface m_tile_sched_if #(
  parameter int DIM_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [DIM_W-1:0] cmd_m_tiles;
  logic [DIM_W-1:0] cmd_n_tiles;
  logic [DIM_W-1:0] cmd_k_tiles;
  logic             step_valid;
  logic             step_ready;
  logic [DIM_W-1:0] step_m;
  logic [DIM_W-1:0] step_n;
  logic [DIM_W-1:0] step_k;
  logic             step_first_k;
  logic             step_last_k;
  logic             drain_req;
  logic             drain_done;
  logic             busy;
  logic             done;

  modport master (
    input  cmd_valid, cmd_m_tiles, cmd_n_tiles, cmd_k_tiles, step_ready, drain_done,
    output cmd_ready, step_valid, step_m, step_n, step_k, step_first_k, step_last_k,
           drain_req, busy, done
  );

  modport slave (
    output cmd_valid, cmd_m_tiles, cmd_n_tiles, cmd_k_tiles, step_ready, drain_done,
    input  cmd_ready, step_valid, step_m, step_n, step_k, step_first_k, step_last_k,
           drain_req, busy, done
  );
endinterface

// File: rtl/m_tile_sched.sv
// GEMM tile-loop scheduler: walks K innermost, then N, then M; flushes the array and
// requests an output drain after each output tile. All outputs are registered.
module m_tile_sched #(
  parameter int DIM_W     = 8,
  parameter int ARRAY_LAT = 4
) (
  input  logic           clk,
  input  logic           rst,
  m_tile_sched_if.master io
);
  typedef enum logic [2:0] {
    S_IDLE,
    S_STEP,
    S_FLUSH,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam int LAT_W = (ARRAY_LAT > 1) ? $clog2(ARRAY_LAT + 1) : 1;

  state_t           state_q, state_d;
  logic [DIM_W-1:0] m_tiles_q, m_tiles_d;
  logic [DIM_W-1:0] n_tiles_q, n_tiles_d;
  logic [DIM_W-1:0] k_tiles_q, k_tiles_d;
  logic [DIM_W-1:0] m_q, m_d;
  logic [DIM_W-1:0] n_q, n_d;
  logic [DIM_W-1:0] k_q, k_d;
  logic [LAT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             step_valid_q, step_valid_d;
  logic             first_k_q, first_k_d;
  logic             last_k_q, last_k_d;
  logic             drain_req_q, drain_req_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  always_comb begin
    state_d     = state_q;
    m_tiles_d   = m_tiles_q;
    n_tiles_d   = n_tiles_q;
    k_tiles_d   = k_tiles_q;
    m_d         = m_q;
    n_d         = n_q;
    k_d         = k_q;
    flush_cnt_d = flush_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (io.cmd_valid && cmd_ready_q) begin
          m_tiles_d = io.cmd_m_tiles;
          n_tiles_d = io.cmd_n_tiles;
          k_tiles_d = io.cmd_k_tiles;
          m_d       = '0;
          n_d       = '0;
          k_d       = '0;
          if (io.cmd_m_tiles == '0 || io.cmd_n_tiles == '0 || io.cmd_k_tiles == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_STEP;
          end
        end
      end
      S_STEP: begin
        if (io.step_ready) begin
          if (k_q == k_tiles_q - DIM_W'(1)) begin
            // A zero-latency array needs no flush; drain right after the last K step.
            if (ARRAY_LAT == 0) begin
              state_d = S_DRAIN;
            end else begin
              state_d     = S_FLUSH;
              flush_cnt_d = LAT_W'(ARRAY_LAT);
            end
          end else begin
            k_d = k_q + DIM_W'(1);
          end
        end
      end
      S_FLUSH: begin
        flush_cnt_d = flush_cnt_q - LAT_W'(1);
        if (flush_cnt_q == LAT_W'(1)) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (io.drain_done) begin
          k_d = '0;
          if (n_q != n_tiles_q - DIM_W'(1)) begin
            n_d     = n_q + DIM_W'(1);
            state_d = S_STEP;
          end else begin
            n_d = '0;
            if (m_q != m_tiles_q - DIM_W'(1)) begin
              m_d     = m_q + DIM_W'(1);
              state_d = S_STEP;
            end else begin
              state_d = S_DONE;
            end
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they line up with state_q.
    cmd_ready_d  = (state_d == S_IDLE);
    step_valid_d = (state_d == S_STEP);
    drain_req_d  = (state_d == S_DRAIN);
    busy_d       = (state_d != S_IDLE);
    done_d       = (state_d == S_DONE);
    first_k_d    = (k_d == '0);
    last_k_d     = (k_d == k_tiles_d - DIM_W'(1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      m_tiles_q    <= '0;
      n_tiles_q    <= '0;
      k_tiles_q    <= '0;
      m_q          <= '0;
      n_q          <= '0;
      k_q          <= '0;
      flush_cnt_q  <= '0;
      cmd_ready_q  <= 1'b1;
      step_valid_q <= 1'b0;
      first_k_q    <= 1'b0;
      last_k_q     <= 1'b0;
      drain_req_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      m_tiles_q    <= m_tiles_d;
      n_tiles_q    <= n_tiles_d;
      k_tiles_q    <= k_tiles_d;
      m_q          <= m_d;
      n_q          <= n_d;
      k_q          <= k_d;
      flush_cnt_q  <= flush_cnt_d;
      cmd_ready_q  <= cmd_ready_d;
      step_valid_q <= step_valid_d;
      first_k_q    <= first_k_d;
      last_k_q     <= last_k_d;
      drain_req_q  <= drain_req_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign io.cmd_ready    = cmd_ready_q;
  assign io.step_valid   = step_valid_q;
  assign io.step_m       = m_q;
  assign io.step_n       = n_q;
  assign io.step_k       = k_q;
  assign io.step_first_k = first_k_q;
  assign io.step_last_k  = last_k_q;
  assign io.drain_req    = drain_req_q;
  assign io.busy         = busy_q;
  assign io.done         = done_q;
endmodule
